// File: rtl/complex_mult_host_if.sv
// Host-side bridge for the complex multiplier: operand FIFO toward the multiplier,
// result FIFO back to the host, credit-limited issue so results are never refused.
module complex_mult_host_if #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    sw_rst,
  input  logic                    host_wr_en,
  input  logic [4*DATA_WIDTH-1:0] host_wr_data,
  output logic                    host_wr_full,
  input  logic                    host_rd_en,
  output logic [4*DATA_WIDTH-1:0] host_rd_data,
  output logic                    host_rd_empty,
  output logic                    op_val,
  input  logic                    op_ready,
  output logic [4*DATA_WIDTH-1:0] op_data,
  input  logic                    res_val,
  output logic                    res_ready,
  input  logic [4*DATA_WIDTH-1:0] res_data,
  output logic [CNT_WIDTH-1:0]    issued_cnt,
  output logic [CNT_WIDTH-1:0]    done_cnt,
  output logic [2:0]              err_flags
);

  localparam int WW = 4 * DATA_WIDTH;
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
  localparam logic [CW:0]   CREDIT_C = (CW + 1)'(FIFO_DEPTH);

  logic [WW-1:0] op_mem  [FIFO_DEPTH];
  logic [WW-1:0] res_mem [FIFO_DEPTH];
  logic [PW-1:0] op_wr_ptr, op_rd_ptr, res_wr_ptr, res_rd_ptr;
  logic [CW-1:0] op_count, res_count, outstanding;

  logic op_full, op_empty, res_full, res_empty;
  logic credit_ok;
  logic [CW:0] credit_sum;
  logic op_push, op_pop, res_acc, res_push, res_pop;
  logic spurious, rd_underflow, wr_overflow;

  assign op_full   = (op_count == DEPTH_C);
  assign op_empty  = (op_count == '0);
  assign res_full  = (res_count == DEPTH_C);
  assign res_empty = (res_count == '0);

  // Every issued operand reserves a result slot until the host drains it.
  assign credit_sum = {1'b0, outstanding} + {1'b0, res_count};
  assign credit_ok  = (credit_sum < CREDIT_C);

  assign op_val        = !op_empty && credit_ok;
  assign op_data       = op_empty ? '0 : op_mem[op_rd_ptr];
  assign host_wr_full  = op_full;
  assign res_ready     = !res_full;
  assign host_rd_empty = res_empty;
  assign host_rd_data  = res_empty ? '0 : res_mem[res_rd_ptr];

  assign op_push      = host_wr_en && !op_full;
  assign op_pop       = op_val && op_ready;
  assign res_acc      = res_val && res_ready;
  assign res_push     = res_acc && (outstanding != '0);
  assign spurious     = res_acc && (outstanding == '0);
  assign res_pop      = host_rd_en && !res_empty;
  assign rd_underflow = host_rd_en && res_empty;
  assign wr_overflow  = host_wr_en && op_full;

  always_ff @(posedge clk) begin
    if (op_push && !sw_rst) op_mem[op_wr_ptr] <= host_wr_data;
    if (res_push && !sw_rst) res_mem[res_wr_ptr] <= res_data;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      op_wr_ptr   <= '0;
      op_rd_ptr   <= '0;
      op_count    <= '0;
      res_wr_ptr  <= '0;
      res_rd_ptr  <= '0;
      res_count   <= '0;
      outstanding <= '0;
      issued_cnt  <= '0;
      done_cnt    <= '0;
      err_flags   <= '0;
    end else if (sw_rst) begin
      op_wr_ptr   <= '0;
      op_rd_ptr   <= '0;
      op_count    <= '0;
      res_wr_ptr  <= '0;
      res_rd_ptr  <= '0;
      res_count   <= '0;
      outstanding <= '0;
      issued_cnt  <= '0;
      done_cnt    <= '0;
      err_flags   <= '0;
    end else begin
      if (op_push)  op_wr_ptr  <= op_wr_ptr + PW'(1);
      if (op_pop)   op_rd_ptr  <= op_rd_ptr + PW'(1);
      if (res_push) res_wr_ptr <= res_wr_ptr + PW'(1);
      if (res_pop)  res_rd_ptr <= res_rd_ptr + PW'(1);
      op_count    <= op_count + CW'(op_push) - CW'(op_pop);
      res_count   <= res_count + CW'(res_push) - CW'(res_pop);
      outstanding <= outstanding + CW'(op_pop) - CW'(res_push);
      issued_cnt  <= issued_cnt + CNT_WIDTH'(op_pop);
      done_cnt    <= done_cnt + CNT_WIDTH'(res_push);
      err_flags   <= err_flags | {spurious, rd_underflow, wr_overflow};
    end
  end

endmodule

// File: tb/tb_complex_mult_host_if.sv
// Bench for complex_mult_host_if: queue-based reference model checked every cycle,
// a behavioural multiplier stub, and directed scenarios with literal expectations.
module tb_complex_mult_host_if;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rstn, sw_rst;
  logic        host_wr_en, host_rd_en;
  logic [31:0] host_wr_data, host_rd_data;
  logic        host_wr_full, host_rd_empty;
  logic        op_val, op_ready, res_val, res_ready;
  logic [31:0] op_data, res_data;
  logic [15:0] issued_cnt, done_cnt;
  logic [2:0]  err_flags;

  int n_chk = 0;
  int n_pass = 0;
  bit chk_en = 1'b0;
  bit spur_req = 1'b0;

  always #5 clk = ~clk;

  complex_mult_host_if #(.DATA_WIDTH(8), .FIFO_DEPTH(DEPTH), .CNT_WIDTH(16)) dut (
    .clk(clk), .rstn(rstn), .sw_rst(sw_rst),
    .host_wr_en(host_wr_en), .host_wr_data(host_wr_data), .host_wr_full(host_wr_full),
    .host_rd_en(host_rd_en), .host_rd_data(host_rd_data), .host_rd_empty(host_rd_empty),
    .op_val(op_val), .op_ready(op_ready), .op_data(op_data),
    .res_val(res_val), .res_ready(res_ready), .res_data(res_data),
    .issued_cnt(issued_cnt), .done_cnt(done_cnt), .err_flags(err_flags)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h required %h", name, got, exp);
  endtask

  function automatic logic [31:0] cmul(input logic [31:0] w);
    logic signed [7:0]  a, b, c, d;
    logic signed [15:0] re, im;
    a = w[31:24]; b = w[23:16]; c = w[15:8]; d = w[7:0];
    re = a * c - b * d;
    im = a * d + b * c;
    return {re, im};
  endfunction

  // Reference model: FIFO contents as queues, credits as plain integer arithmetic.
  logic [31:0] m_op[$];
  logic [31:0] m_res[$];
  int          m_out;
  logic [15:0] m_iss, m_done;
  logic [2:0]  m_err;

  always @(posedge clk or negedge rstn) begin : model
    bit iss, acc, rdp, wrp;
    if (!rstn || sw_rst) begin
      m_op.delete(); m_res.delete();
      m_out = 0; m_iss = '0; m_done = '0; m_err = '0;
    end else begin
      iss = (m_op.size() > 0) && (m_out + m_res.size() < DEPTH) && op_ready;
      acc = res_val && (m_res.size() < DEPTH);
      rdp = host_rd_en && (m_res.size() > 0);
      wrp = host_wr_en && (m_op.size() < DEPTH);
      if (host_wr_en && !wrp) m_err[0] = 1'b1;
      if (host_rd_en && !rdp) m_err[1] = 1'b1;
      if (rdp) void'(m_res.pop_front());
      if (iss) begin void'(m_op.pop_front()); m_iss++; end
      if (acc) begin
        if (m_out > 0) begin m_res.push_back(res_data); m_out--; m_done++; end
        else m_err[2] = 1'b1;
      end
      if (iss) m_out++;
      if (wrp) m_op.push_back(host_wr_data);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("op_val", 32'(op_val), 32'((m_op.size() > 0) && (m_out + m_res.size() < DEPTH)));
      check("op_data", op_data, (m_op.size() > 0) ? m_op[0] : 32'h0);
      check("host_wr_full", 32'(host_wr_full), 32'(m_op.size() == DEPTH));
      check("host_rd_empty", 32'(host_rd_empty), 32'(m_res.size() == 0));
      check("host_rd_data", host_rd_data, (m_res.size() > 0) ? m_res[0] : 32'h0);
      check("res_ready", 32'(res_ready), 32'(m_res.size() < DEPTH));
      check("issued_cnt", 32'(issued_cnt), 32'(m_iss));
      check("done_cnt", 32'(done_cnt), 32'(m_done));
      check("err_flags", 32'(err_flags), 32'(m_err));
    end
  end

  // Multiplier stub: two-cycle pipeline, optional one-shot spurious result.
  logic [31:0] pipe_data[$];
  int          pipe_due[$];
  initial begin : stub
    int cyc;
    bit hs_op, hs_res, from_pipe, srst;
    logic [31:0] d;
    cyc = 0; from_pipe = 0;
    res_val = 1'b0; res_data = '0;
    forever begin
      @(negedge clk);
      hs_op = op_val && op_ready;
      d = op_data;
      hs_res = res_val && res_ready;
      srst = sw_rst;
      @(posedge clk); #1;
      cyc++;
      if (hs_res && from_pipe) begin void'(pipe_data.pop_front()); void'(pipe_due.pop_front()); end
      if (hs_op) begin pipe_data.push_back(cmul(d)); pipe_due.push_back(cyc + 2); end
      if (!rstn || srst) begin pipe_data.delete(); pipe_due.delete(); end
      if (pipe_data.size() > 0 && pipe_due[0] <= cyc) begin
        res_val = 1'b1; res_data = pipe_data[0]; from_pipe = 1;
      end else if (spur_req) begin
        res_val = 1'b1; res_data = 32'hDEADBEEF; from_pipe = 0; spur_req = 1'b0;
      end else begin
        res_val = 1'b0; from_pipe = 0;
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic write_op(input logic [31:0] w);
    host_wr_en = 1'b1; host_wr_data = w;
    tick();
    host_wr_en = 1'b0;
  endtask

  task automatic read_res();
    host_rd_en = 1'b1;
    tick();
    host_rd_en = 1'b0;
  endtask

  task automatic wait_result(input string name, input int max_cyc);
    for (int i = 0; i < max_cyc && host_rd_empty; i++) tick();
    check(name, 32'(host_rd_empty), 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rstn = 1'b0; sw_rst = 1'b0; host_wr_en = 1'b0; host_rd_en = 1'b0;
    host_wr_data = '0; op_ready = 1'b1;
    tick(3);
    chk_en = 1'b1;
    check("rst_op_val", 32'(op_val), 32'h0);
    check("rst_res_ready", 32'(res_ready), 32'h1);
    check("rst_rd_empty", 32'(host_rd_empty), 32'h1);
    check("rst_err", 32'(err_flags), 32'h0);
    rstn = 1'b1;
    tick();

    // single operation
    write_op(32'h03020405);
    check("t1_op_val_latency", 32'(op_val), 32'h1);
    wait_result("t1_result_wait", 20);
    check("t1_rd_data", host_rd_data, 32'h00020017);
    check("t1_issued", 32'(issued_cnt), 32'h1);
    check("t1_done", 32'(done_cnt), 32'h1);
    read_res();
    check("t1_empty_after_read", 32'(host_rd_empty), 32'h1);

    // backpressure
    op_ready = 1'b0;
    write_op(32'h01020304);
    for (int i = 0; i < 5; i++) begin
      check("t2_op_val_held", 32'(op_val), 32'h1);
      check("t2_op_data_held", op_data, 32'h01020304);
      tick();
    end
    op_ready = 1'b1;
    tick();
    check("t2_issued_once", 32'(issued_cnt), 32'h2);
    check("t2_op_val_after", 32'(op_val), 32'h0);
    wait_result("t2_result_wait", 20);
    check("t2_rd_data", host_rd_data, 32'hFFFB000A);
    read_res();

    // credit limit
    for (int i = 0; i < 8; i++) write_op({8'(i + 1), 8'(i), 8'd2, 8'd1});
    tick(8);
    check("t3_issued_stop", 32'(issued_cnt), 32'h6);
    check("t3_op_val_off", 32'(op_val), 32'h0);
    check("t3_wr_full", 32'(host_wr_full), 32'h1);
    write_op(32'h0A0B0C0D);
    check("t3_overflow", 32'(err_flags), 32'h1);
    read_res();
    tick(6);
    check("t3_one_more_issue", 32'(issued_cnt), 32'h7);

    // underflow and software reset
    sw_rst = 1'b1; tick(); sw_rst = 1'b0;
    check("t4_clear_err", 32'(err_flags), 32'h0);
    check("t4_clear_empty", 32'(host_rd_empty), 32'h1);
    read_res();
    check("t4_underflow", 32'(err_flags), 32'h2);
    sw_rst = 1'b1; tick(); sw_rst = 1'b0;
    check("t4_swrst_err", 32'(err_flags), 32'h0);
    check("t4_swrst_rd_empty", 32'(host_rd_empty), 32'h1);
    check("t4_swrst_wr_full", 32'(host_wr_full), 32'h0);
    check("t4_swrst_issued", 32'(issued_cnt), 32'h0);

    // spurious result
    spur_req = 1'b1;
    tick(4);
    check("t5_no_push", 32'(host_rd_empty), 32'h1);
    check("t5_spurious_err", 32'(err_flags), 32'h4);
    check("t5_done_unchanged", 32'(done_cnt), 32'h0);

    // async reset with operations in flight
    write_op(32'h02030405);
    write_op(32'h01010101);
    tick();
    #2 rstn = 1'b0;
    #1;
    check("t6_rst_op_val", 32'(op_val), 32'h0);
    check("t6_rst_op_data", op_data, 32'h0);
    check("t6_rst_rd_empty", 32'(host_rd_empty), 32'h1);
    check("t6_rst_rd_data", host_rd_data, 32'h0);
    check("t6_rst_res_ready", 32'(res_ready), 32'h1);
    check("t6_rst_issued", 32'(issued_cnt), 32'h0);
    check("t6_rst_err", 32'(err_flags), 32'h0);
    tick(2);
    rstn = 1'b1;
    tick();
    write_op(32'h03020405);
    wait_result("t6_result_wait", 20);
    check("t6_rd_data", host_rd_data, 32'h00020017);
    check("t6_issued", 32'(issued_cnt), 32'h1);
    check("t6_done", 32'(done_cnt), 32'h1);
    check("t6_err", 32'(err_flags), 32'h0);
    read_res();
    tick(3);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
